// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: funct3 encodings, FSM states,
// and the wait-state counter width.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, store replication, load extension.
// DMEM_MISALIGN_TRAP_EN: misaligned half/word raises err; otherwise low address bits are forced to 0.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] raw_i,
    output logic [3:0]  be_o,
    output logic [31:0] wword_o,
    output logic [31:0] ldata_o,
    output logic        err_o
);

    logic [1:0]  lane_eff;
    logic        size_err;
    logic [31:0] shifted;

    always_comb begin
        size_err = 1'b0;
        lane_eff = 2'b00;
        be_o     = '0;
        wword_o  = wdata_i;
        case (funct3_i)
            F3_B, F3_BU: begin
                size_err = is_store_i && funct3_i[2];
                lane_eff = lane_i;
                be_o     = 4'b0001 << lane_eff;
                wword_o  = {4{wdata_i[7:0]}};
            end
            F3_H, F3_HU: begin
                size_err = is_store_i && funct3_i[2];
                lane_eff = {lane_i[1], 1'b0};
                be_o     = 4'b0011 << lane_eff;
                wword_o  = {2{wdata_i[15:0]}};
            end
            F3_W: begin
                lane_eff = 2'b00;
                be_o     = 4'b1111;
                wword_o  = wdata_i;
            end
            default: size_err = 1'b1;
        endcase
    end

    always_comb begin
        shifted = raw_i >> {lane_eff, 3'b000};
        case (funct3_i)
            F3_B:    ldata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ldata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    ldata_o = shifted;
            F3_BU:   ldata_o = {24'h0, shifted[7:0]};
            F3_HU:   ldata_o = {16'h0, shifted[15:0]};
            default: ldata_o = '0;
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic mis;
    assign mis   = (funct3_i[1:0] == 2'b01 && lane_i[0]) ||
                   (funct3_i[1:0] == 2'b10 && lane_i != 2'b00);
    assign err_o = size_err || mis;
`else
    assign err_o = size_err;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port: one request at a time, wait-state
// delayed single-cycle response. Optional DMEM_MISALIGN_TRAP_EN enables misalignment faults.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LAST = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

    logic [31:0]      mem_q [DEPTH_WORDS];
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             rsp_valid_q;
    logic [31:0]      rsp_rdata_q;
    logic             rsp_err_q;

    logic             accept;
    logic             enter_resp;
    logic             cur_we;
    logic [2:0]       cur_f3;
    logic [31:0]      cur_addr;
    logic [31:0]      cur_wdata;
    logic [AW-1:0]    idx;
    logic             range_err;
    logic [3:0]       be;
    logic [31:0]      wword;
    logic [31:0]      ldata;
    logic             align_err;
    logic             err;

    assign req_ready = reset && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    // With zero wait states the store commits on the accept edge itself, so the
    // datapath sees the live request in IDLE and the latched copy otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_we    = req_we;
            cur_f3    = req_funct3;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_we    = we_q;
            cur_f3    = f3_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    assign idx        = cur_addr[AW+1:2];
    assign range_err  = |cur_addr[31:AW+2];
    assign err        = range_err || align_err;
    assign enter_resp = (state_q == ST_IDLE && accept && WAIT_CYCLES == 0) ||
                        (state_q == ST_WAIT && cnt_q == CNT_LAST);

    dmem_lane_align u_align (
        .is_store_i (cur_we),
        .funct3_i   (cur_f3),
        .lane_i     (cur_addr[1:0]),
        .wdata_i    (cur_wdata),
        .raw_i      (mem_q[idx]),
        .be_o       (be),
        .wword_o    (wword),
        .ldata_o    (ldata),
        .err_o      (align_err)
    );

    always_ff @(posedge clk) begin
        if (reset && enter_resp && cur_we && !err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= '0;
                        if (WAIT_CYCLES == 0) state_q <= ST_RESP;
                        else                  state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == CNT_LAST) state_q <= ST_RESP;
                    else                   cnt_q   <= cnt_q + CNT_W'(1);
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err;
                    rsp_rdata_q <= (err || we_q) ? '0 : ldata;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=256, WAIT_CYCLES=1): vector table,
// response scoreboard, plus reset-abort and busy-hold sequences.
module tb_dmem_responder;

    localparam int unsigned WAITC = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(WAITC)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
        string       name;
    } sb_t;

    sb_t  sb[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
                chk({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
                chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(WAITC + 1));
            end
        end
    end

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] er,
                                input logic ee, input string nm);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee; v.name = nm;
        return v;
    endfunction

    // Present one request at a negedge, hold until accepted, then wait for the scoreboard to drain.
    task automatic do_req(input vec_t v);
        int n;
        sb_t e;
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            chk({v.name, "_accept_timeout"}, 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        e.rdata = v.exp_rdata; e.err = v.exp_err; e.acc = cyc + 1; e.name = v.name;
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk({v.name, "_rsp_timeout"}, 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sb_t e;
        vec_t v;
        int n;

        vecs.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, "sw_10"));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, "lw_10"));
        vecs.push_back(mk(1, 3'b000, 32'h11, 32'hFFFFFF5A, 32'h0, 0, "sb_11"));
        vecs.push_back(mk(0, 3'b100, 32'h11, 32'h0, 32'h0000005A, 0, "lbu_11"));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'hDEAD5AEF, 0, "lw_10_after_sb"));
        vecs.push_back(mk(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 0, "lb_13"));
        vecs.push_back(mk(0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0, "lhu_12"));
        vecs.push_back(mk(0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 0, "lh_12"));
        vecs.push_back(mk(0, 3'b010, 32'h400, 32'h0, 32'h0, 1, "lw_range"));
        vecs.push_back(mk(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, "ld_f3_011"));
        vecs.push_back(mk(0, 3'b110, 32'h10, 32'h0, 32'h0, 1, "ld_f3_110"));
        vecs.push_back(mk(1, 3'b100, 32'h10, 32'h0, 32'h0, 1, "st_f3_100"));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'hDEAD5AEF, 0, "lw_10_no_bad_st"));
        vecs.push_back(mk(1, 3'b010, 32'h14, 32'h0, 32'h0, 0, "sw_14_zero"));
        vecs.push_back(mk(1, 3'b001, 32'h16, 32'hFFFF8001, 32'h0, 0, "sh_16"));
        vecs.push_back(mk(0, 3'b010, 32'h14, 32'h0, 32'h80010000, 0, "lw_14_after_sh"));
        vecs.push_back(mk(0, 3'b001, 32'h16, 32'h0, 32'hFFFF8001, 0, "lh_16"));
        vecs.push_back(mk(1, 3'b010, 32'h0, 32'h11111111, 32'h0, 0, "sw_00"));
        vecs.push_back(mk(1, 3'b010, 32'h400, 32'h22222222, 32'h0, 1, "sw_range"));
        vecs.push_back(mk(0, 3'b010, 32'h0, 32'h0, 32'h11111111, 0, "lw_00_no_alias"));
        vecs.push_back(mk(1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 0, "sw_20"));
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs.push_back(mk(1, 3'b010, 32'h21, 32'h12345678, 32'h0, 1, "sw_21_mis"));
        vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 0, "lw_20_after_mis"));
        vecs.push_back(mk(0, 3'b001, 32'h13, 32'h0, 32'h0, 1, "lh_13_mis"));
`else
        vecs.push_back(mk(1, 3'b010, 32'h21, 32'h12345678, 32'h0, 0, "sw_21_mis"));
        vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0, 32'h12345678, 0, "lw_20_after_mis"));
        vecs.push_back(mk(0, 3'b001, 32'h13, 32'h0, 32'hFFFFDEAD, 0, "lh_13_mis"));
`endif
        vecs.push_back(mk(1, 3'b010, 32'h30, 32'h55AA55AA, 32'h0, 0, "sw_30"));

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);

        // Reset during WAIT drops the pending store and suppresses the response.
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h30; req_wdata = 32'h0BADF00D;
        chk("abort_ready_before", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_ready_in_reset", 32'(req_ready), 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_req(mk(0, 3'b010, 32'h30, 32'h0, 32'h55AA55AA, 0, "lw_30_after_abort"));

        // req_valid held through the busy period: fields change after accept, ready stays low.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0;
        chk("hold_ready_first", 32'(req_ready), 32'd1);
        e.rdata = 32'hDEAD5AEF; e.err = 1'b0; e.acc = cyc + 1; e.name = "hold_first";
        sb.push_back(e);
        @(negedge clk);
        req_addr = 32'h14;
        for (int k = 0; k <= int'(WAITC); k++) begin
            chk("hold_ready_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        chk("hold_ready_again", 32'(req_ready), 32'd1);
        e.rdata = 32'h80010000; e.err = 1'b0; e.acc = cyc + 1; e.name = "hold_second";
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("hold_rsp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
